// File: rtl/vga_pkg.sv
// Shared definitions for the VGA display engine: default 640x480 timing,
// colour-mode encodings and the line/frame total helper.
package vga_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    typedef enum logic [1:0] {
        MODE_SRC   = 2'd0,
        MODE_SOLID = 2'd1,
        MODE_GATE  = 2'd2,
        MODE_XOR   = 2'd3
    } mode_e;

    function automatic int unsigned vga_total(input int unsigned active,
                                              input int unsigned fp,
                                              input int unsigned sync,
                                              input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_core.sv
// Raster counters, sync/active decode and completed-frame counter.
// Sync outputs are polarity-free: high means "inside the sync window".
module vga_timing_core
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned FRAME_W  = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    output logic [9:0]         x_o,
    output logic [9:0]         y_o,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic               active_o,
    output logic               wrap_o,
    output logic [FRAME_W-1:0] frame_cnt_o
);

    localparam int unsigned H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]         h_q, h_d;
    logic [9:0]         v_q, v_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               h_last, v_last;

    always_comb begin
        h_last  = (h_q == H_LAST);
        v_last  = (v_q == V_LAST);
        h_d     = h_last ? '0 : h_q + 10'd1;
        v_d     = v_q;
        frame_d = frame_q;
        if (h_last) begin
            v_d = v_last ? '0 : v_q + 10'd1;
        end
        if (h_last && v_last) begin
            frame_d = frame_q + FRAME_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            h_q     <= '0;
            v_q     <= '0;
            frame_q <= '0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            frame_q <= frame_d;
        end
    end

    assign x_o         = h_q;
    assign y_o         = v_q;
    assign hsync_o     = (h_q >= HS_START) && (h_q < HS_END);
    assign vsync_o     = (v_q >= VS_START) && (v_q < VS_END);
    assign active_o    = (h_q < H_ACT) && (v_q < V_ACT);
    assign wrap_o      = h_last && v_last;
    assign frame_cnt_o = frame_q;

endmodule

// File: rtl/vga_display_engine.sv
// VGA display engine: timing core, frame-synchronous shadowed config,
// source mux and registered pins with matched sync/colour latency.
module vga_display_engine
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
    parameter int unsigned H_FP        = DEF_H_FP,
    parameter int unsigned H_SYNC      = DEF_H_SYNC,
    parameter int unsigned H_BP        = DEF_H_BP,
    parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
    parameter int unsigned V_FP        = DEF_V_FP,
    parameter int unsigned V_SYNC      = DEF_V_SYNC,
    parameter int unsigned V_BP        = DEF_V_BP,
    parameter logic        HS_POL      = 1'b0,
    parameter logic        VS_POL      = 1'b0,
    parameter int unsigned COLOR_BITS  = 2,
    parameter int unsigned NUM_SRC     = 4,
    parameter int unsigned SRC_LAT     = 1,
    parameter int unsigned SCALE_SHIFT = 3,
    parameter int unsigned FRAME_W     = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cfg_valid,
    input  logic [$clog2(NUM_SRC)-1:0]        cfg_sel,
    input  logic [1:0]                        cfg_mode,
    input  logic [3*COLOR_BITS-1:0]           cfg_color,
    input  logic [NUM_SRC*3*COLOR_BITS-1:0]   src_pixel,
    output logic [9:0]                        x,
    output logic [9:0]                        y,
    output logic [9:0]                        xcoor,
    output logic [9:0]                        ycoor,
    output logic                              sof,
    output logic [FRAME_W-1:0]                frame_cnt,
    output logic                              hs,
    output logic                              vs,
    output logic [3*COLOR_BITS-1:0]           rgb
);

    localparam int unsigned PW   = 3 * COLOR_BITS;
    localparam int unsigned SELW = $clog2(NUM_SRC);
    localparam logic [SELW:0] NSRC = (SELW + 1)'(NUM_SRC);

    typedef struct packed {
        logic            hs;
        logic            vs;
        logic            act;
        logic [SELW-1:0] sel;
        mode_e           mode;
        logic [PW-1:0]   color;
    } stage_t;

    localparam stage_t STAGE_IDLE = '0;

    logic hsync_w, vsync_w, active_w, wrap_w;

    vga_timing_core #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .FRAME_W  (FRAME_W)
    ) u_timing (
        .clk_i       (clk),
        .rst_i       (rst),
        .x_o         (x),
        .y_o         (y),
        .hsync_o     (hsync_w),
        .vsync_o     (vsync_w),
        .active_o    (active_w),
        .wrap_o      (wrap_w),
        .frame_cnt_o (frame_cnt)
    );

    assign xcoor = x >> SCALE_SHIFT;
    assign ycoor = y >> SCALE_SHIFT;
    assign sof   = (x == '0) && (y == '0);

    logic [SELW-1:0] pend_sel_q, pend_sel_d, live_sel_q, live_sel_d;
    mode_e           pend_mode_q, pend_mode_d, live_mode_q, live_mode_d;
    logic [PW-1:0]   pend_color_q, pend_color_d, live_color_q, live_color_d;
    logic            pend_flag_q, pend_flag_d;

    // Promotion reads the old pending value, so a write landing on the wrap
    // edge is held for the following frame.
    always_comb begin
        pend_sel_d   = pend_sel_q;
        pend_mode_d  = pend_mode_q;
        pend_color_d = pend_color_q;
        pend_flag_d  = pend_flag_q;
        live_sel_d   = live_sel_q;
        live_mode_d  = live_mode_q;
        live_color_d = live_color_q;
        if (wrap_w && pend_flag_q) begin
            live_sel_d   = pend_sel_q;
            live_mode_d  = pend_mode_q;
            live_color_d = pend_color_q;
            pend_flag_d  = 1'b0;
        end
        if (cfg_valid) begin
            pend_sel_d   = cfg_sel;
            pend_mode_d  = mode_e'(cfg_mode);
            pend_color_d = cfg_color;
            pend_flag_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_sel_q   <= '0;
            pend_mode_q  <= MODE_SRC;
            pend_color_q <= '0;
            pend_flag_q  <= 1'b0;
            live_sel_q   <= '0;
            live_mode_q  <= MODE_SRC;
            live_color_q <= '0;
        end else begin
            pend_sel_q   <= pend_sel_d;
            pend_mode_q  <= pend_mode_d;
            pend_color_q <= pend_color_d;
            pend_flag_q  <= pend_flag_d;
            live_sel_q   <= live_sel_d;
            live_mode_q  <= live_mode_d;
            live_color_q <= live_color_d;
        end
    end

    stage_t stage0, tap;

    assign stage0 = '{hs: hsync_w, vs: vsync_w, act: active_w,
                      sel: live_sel_q, mode: live_mode_q, color: live_color_q};

    // Live config travels with the coordinate so it meets the matching pixel.
    generate
        if (SRC_LAT == 0) begin : g_nodly
            assign tap = stage0;
        end else begin : g_dly
            stage_t dly_q [SRC_LAT];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int unsigned i = 0; i < SRC_LAT; i++) begin
                        dly_q[i] <= STAGE_IDLE;
                    end
                end else begin
                    dly_q[0] <= stage0;
                    for (int unsigned i = 1; i < SRC_LAT; i++) begin
                        dly_q[i] <= dly_q[i-1];
                    end
                end
            end
            assign tap = dly_q[SRC_LAT-1];
        end
    endgenerate

    logic [PW-1:0]   src_arr [NUM_SRC];
    logic [SELW-1:0] src_sel;
    logic [PW-1:0]   s, pix;
    logic [PW-1:0]   rgb_q, rgb_d;
    logic            hs_q, hs_d, vs_q, vs_d;

    always_comb begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            src_arr[i] = src_pixel[i*PW +: PW];
        end
        src_sel = ({1'b0, tap.sel} < NSRC) ? tap.sel : '0;
        s       = src_arr[src_sel];
        pix     = s;
        case (tap.mode)
            MODE_SRC:   pix = s;
            MODE_SOLID: pix = tap.color;
            MODE_GATE:  pix = s[0] ? tap.color : '0;
            MODE_XOR:   pix = tap.color ^ s;
            default:    pix = s;
        endcase
        rgb_d = tap.act ? pix : '0;
        hs_d  = tap.hs ? HS_POL : ~HS_POL;
        vs_d  = tap.vs ? VS_POL : ~VS_POL;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            rgb_q <= '0;
        end else begin
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            rgb_q <= rgb_d;
        end
    end

    assign hs  = hs_q;
    assign vs  = vs_q;
    assign rgb = rgb_q;

endmodule

// File: tb/tb_vga_display_engine.sv
// Directed/randomised bench for vga_display_engine on a 14x7 raster with a
// frame-level config model and a one-cycle-latency pixel source.
module tb_vga_display_engine;

    localparam int unsigned HT = 14;
    localparam int unsigned VT = 7;
    localparam int unsigned FT = HT * VT;

    typedef struct {
        int unsigned frm;
        logic [1:0]  sel;
        logic [1:0]  mode;
        logic [5:0]  color;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic [1:0]  cfg_sel;
    logic [1:0]  cfg_mode;
    logic [5:0]  cfg_color;
    logic [23:0] src_pixel;
    logic [9:0]  x, y, xcoor, ycoor;
    logic        sof, hs, vs;
    logic [7:0]  frame_cnt;
    logic [5:0]  rgb;

    vga_display_engine #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .HS_POL (1'b0), .VS_POL (1'b0),
        .COLOR_BITS (2), .NUM_SRC (4), .SRC_LAT (1),
        .SCALE_SHIFT (3), .FRAME_W (8)
    ) dut (
        .clk (clk), .rst (rst),
        .cfg_valid (cfg_valid), .cfg_sel (cfg_sel), .cfg_mode (cfg_mode),
        .cfg_color (cfg_color), .src_pixel (src_pixel),
        .x (x), .y (y), .xcoor (xcoor), .ycoor (ycoor), .sof (sof),
        .frame_cnt (frame_cnt), .hs (hs), .vs (vs), .rgb (rgb)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned n = 0;
    logic [5:0]  lut [4][FT];
    logic [23:0] src_used;
    wr_t         wq [$];

    task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h (edge %0d)", tag, obs, exp, n);
        end
    endtask

    // Source presents the pixel for the coordinate shown one edge earlier.
    function automatic logic [23:0] src_for(input int unsigned nn);
        logic [23:0] v;
        int unsigned p;
        v = '0;
        if (nn != 0) begin
            p = (nn - 1) % FT;
            for (int i = 0; i < 4; i++) v[i*6 +: 6] = lut[i][p];
        end
        return v;
    endfunction

    // A write seen at edge e is live from frame e/FT+1; the latest such write wins.
    function automatic wr_t live_cfg(input int unsigned f);
        wr_t c;
        c = '{frm: 0, sel: 2'd0, mode: 2'd0, color: 6'd0};
        foreach (wq[i]) if (wq[i].frm <= f) c = wq[i];
        return c;
    endfunction

    function automatic logic [5:0] mode_fn(input logic [1:0] m, input logic [5:0] s,
                                           input logic [5:0] c);
        case (m)
            2'd0:    return s;
            2'd1:    return c;
            2'd2:    return s[0] ? c : 6'd0;
            default: return c ^ s;
        endcase
    endfunction

    task automatic check_reset();
        ck("rst_x", 32'(x), 32'd0);
        ck("rst_y", 32'(y), 32'd0);
        ck("rst_sof", 32'(sof), 32'd1);
        ck("rst_frame", 32'(frame_cnt), 32'd0);
        ck("rst_hs", 32'(hs), 32'd1);
        ck("rst_vs", 32'(vs), 32'd1);
        ck("rst_rgb", 32'(rgb), 32'd0);
    endtask

    task automatic check_all();
        int unsigned p, ex, ey, c, pc, cx, cy;
        wr_t         cf;
        logic [5:0]  s, er;
        logic        eh, ev;
        p  = n % FT;
        ex = p % HT;
        ey = p / HT;
        ck("x", 32'(x), ex);
        ck("y", 32'(y), ey);
        ck("xcoor", 32'(xcoor), ex >> 3);
        ck("ycoor", 32'(ycoor), ey >> 3);
        ck("sof", 32'(sof), (p == 0) ? 32'd1 : 32'd0);
        ck("frame_cnt", 32'(frame_cnt), (n / FT) % 256);
        if (n < 2) begin
            eh = 1'b1; ev = 1'b1; er = 6'd0;
        end else begin
            c  = n - 2;
            pc = c % FT;
            cx = pc % HT;
            cy = pc / HT;
            cf = live_cfg(c / FT);
            s  = src_used[int'(cf.sel)*6 +: 6];
            eh = !(cx >= 10 && cx < 12);
            ev = (cy != 5);
            er = (cx < 8 && cy < 4) ? mode_fn(cf.mode, s, cf.color) : 6'd0;
        end
        ck("hs", 32'(hs), 32'(eh));
        ck("vs", 32'(vs), 32'(ev));
        ck("rgb", 32'(rgb), 32'(er));
    endtask

    task automatic tick(input logic v, input logic [1:0] sel, input logic [1:0] mode,
                        input logic [5:0] col);
        cfg_valid = v;
        cfg_sel   = sel;
        cfg_mode  = mode;
        cfg_color = col;
        src_used  = src_pixel;
        @(posedge clk);
        n++;
        if (v) wq.push_back('{frm: n / FT + 1, sel: sel, mode: mode, color: col});
        #1;
        cfg_valid = 1'b0;
        src_pixel = src_for(n);
        #2;
        check_all();
    endtask

    task automatic run(input int unsigned k);
        repeat (k) tick(1'b0, 2'd0, 2'd0, 6'd0);
    endtask

    task automatic wr(input logic [1:0] sel, input logic [1:0] mode, input logic [5:0] col);
        tick(1'b1, sel, mode, col);
    endtask

    task automatic run_to_pre_wrap();
        while (((n + 1) % FT) != 0) tick(1'b0, 2'd0, 2'd0, 6'd0);
    endtask

    initial begin
        logic [5:0] v6;
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_sel   = '0;
        cfg_mode  = '0;
        cfg_color = '0;
        src_pixel = '0;
        for (int i = 0; i < 4; i++)
            for (int p = 0; p < int'(FT); p++) lut[i][p] = 6'($urandom);

        #12;
        check_reset();
        #1;
        rst = 1'b0;
        n = 0;
        wq.delete();

        // free run: sync windows and first frame count
        run(110);

        // source 2 constant 2D, selected mid-frame, mode 0
        for (int p = 0; p < int'(FT); p++) lut[2][p] = 6'h2D;
        wr(2'd2, 2'd0, 6'h00);
        run(200);

        // mode 1 solid 3F written mid-frame
        wr(2'd2, 2'd1, 6'h3F);
        run(120);

        // first write mid-frame, second on the wrap edge
        run(30);
        wr(2'd1, 2'd0, 6'($urandom));
        run_to_pre_wrap();
        wr(2'd3, 2'd1, 6'h2A);
        run(200);

        // gate mode with source bit 0 toggling per pixel
        for (int p = 0; p < int'(FT); p++) begin
            v6 = 6'($urandom);
            v6[0] = ((p % int'(HT)) % 2) == 1;
            lut[0][p] = v6;
        end
        wr(2'd0, 2'd2, 6'h15);
        run(200);

        // xor mode on a constant 3F source
        for (int p = 0; p < int'(FT); p++) lut[3][p] = 6'h3F;
        wr(2'd3, 2'd3, 6'h15);
        run(200);

        // random configs at random times, with fresh source data
        repeat (6) begin
            run($urandom_range(1, 150));
            for (int p = 0; p < int'(FT); p++) lut[$urandom_range(0, 3)][p] = 6'($urandom);
            wr(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 6'($urandom));
            if ($urandom_range(0, 1) == 1)
                wr(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 6'($urandom));
        end
        run(200);

        // asynchronous reset mid-line, then restart from (0,0)
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset();
        repeat (3) @(posedge clk);
        #2;
        check_reset();
        #2;
        rst = 1'b0;
        n = 0;
        wq.delete();
        src_pixel = '0;
        run(110);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
